// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage and its neighbours (EX redirect, hazard unit, imem, decode).
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            branch_taken;
  logic            jal;
  logic            jalr;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [31:0]     if_id_instr;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc4;
  logic            if_id_valid;
  logic            flush_id_ex;
  logic            fault;

  modport master (
    input  stall, branch_taken, jal, jalr, pc_target, jalr_target, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid, flush_id_ex, fault
  );

  modport slave (
    output stall, branch_taken, jal, jalr, pc_target, jalr_target, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid, flush_id_ex, fault
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, holds the IF/ID register,
// squashes on EX redirects and halts for good on a misaligned control-flow target.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_if.master  bus
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc4_q, id_pc4_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            flush;

  // JALR outranks JAL outranks branch; only JALR targets get bit 0 cleared.
  assign redirect   = (state_q == RUN) && (bus.jalr || bus.jal || bus.branch_taken);
  assign target     = bus.jalr ? {bus.jalr_target[XLEN-1:1], 1'b0} : bus.pc_target;
  assign misaligned = (target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect && misaligned) state_d = HALT;
  end

  // Redirect is checked before stall: the EX instruction is older than the stalled ones.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    flush    = 1'b0;
    if (state_q == RUN) begin
      if (redirect) begin
        flush    = 1'b1;
        instr_d  = NOP;
        id_pc_d  = '0;
        id_pc4_d = '0;
        valid_d  = 1'b0;
        if (misaligned) fault_d = 1'b1;
        else            pc_d    = target;
      end else if (!bus.stall) begin
        pc_d     = pc_q + PC_STEP;
        instr_d  = bus.imem_rdata;
        id_pc_d  = pc_q;
        id_pc4_d = pc_q + PC_STEP;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP;
      id_pc_q  <= '0;
      id_pc4_q <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = id_pc_q;
  assign bus.if_id_pc4   = id_pc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.flush_id_ex = flush;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free run, redirects, stalls, JALR masking, fault/HALT and PC wrap.
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  fetch_stage_if #(.XLEN(32)) bus_a ();
  fetch_stage_if #(.XLEN(32)) bus_b ();

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP(32'h0000_0013)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP(32'h0000_0013)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Instruction memory returns word = address.
  assign bus_a.imem_rdata = bus_a.imem_addr;
  assign bus_b.imem_rdata = bus_b.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic br, input logic jal, input logic jalr,
                               input logic [31:0] tgt, input logic [31:0] jtgt);
    bus_a.stall        = stall;
    bus_a.branch_taken = br;
    bus_a.jal          = jal;
    bus_a.jalr         = jalr;
    bus_a.pc_target    = tgt;
    bus_a.jalr_target  = jtgt;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfId(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [31:0] pc4, input logic valid);
    checkOutput({tag, ".addr"},  bus_a.imem_addr, addr);
    checkOutput({tag, ".instr"}, bus_a.if_id_instr, instr);
    checkOutput({tag, ".pc"},    bus_a.if_id_pc, pc);
    checkOutput({tag, ".pc4"},   bus_a.if_id_pc4, pc4);
    checkOutput({tag, ".valid"}, 32'(bus_a.if_id_valid), 32'(valid));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    bus_b.stall = 1'b0; bus_b.branch_taken = 1'b0; bus_b.jal = 1'b0; bus_b.jalr = 1'b0;
    bus_b.pc_target = '0; bus_b.jalr_target = '0;
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    checkIfId("reset", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0);
    checkOutput("reset.fault", 32'(bus_a.fault), 32'h0);
    checkOutput("reset.flush", 32'(bus_a.flush_id_ex), 32'h0);
    checkOutput("resetB.addr", bus_b.imem_addr, 32'hFFFF_FFFC);
    rst = 1'b0;

    // Free run; DUT B wraps on its first fetch.
    step();
    checkIfId("run0", 32'h4, 32'h0, 32'h0, 32'h4, 1'b1);
    checkOutput("wrap.addr", bus_b.imem_addr, 32'h0);
    checkOutput("wrap.pc", bus_b.if_id_pc, 32'hFFFF_FFFC);
    checkOutput("wrap.pc4", bus_b.if_id_pc4, 32'h0);
    checkOutput("wrap.fault", 32'(bus_b.fault), 32'h0);
    step();
    checkIfId("run1", 32'h8, 32'h4, 32'h4, 32'h8, 1'b1);
    step();
    checkIfId("run2", 32'hC, 32'h8, 32'h8, 32'hC, 1'b1);
    step();
    checkIfId("run3", 32'h10, 32'hC, 32'hC, 32'h10, 1'b1);

    // Taken branch at pc = 0x10.
    applyStimulus(0, 1, 0, 0, 32'h40, 32'h0);
    checkOutput("br.flush", 32'(bus_a.flush_id_ex), 32'h1);
    step();
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkIfId("br.bubble", 32'h40, 32'h13, 32'h0, 32'h0, 1'b0);
    checkOutput("br.flush_off", 32'(bus_a.flush_id_ex), 32'h0);
    step();
    checkIfId("br.target", 32'h44, 32'h40, 32'h40, 32'h44, 1'b1);

    // Land at 0x1C, then stall 3 cycles with pc = 0x20.
    applyStimulus(0, 0, 1, 0, 32'h1C, 32'h0);
    step();
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    checkIfId("pre_stall", 32'h20, 32'h1C, 32'h1C, 32'h20, 1'b1);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("stall.flush", 32'(bus_a.flush_id_ex), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkIfId($sformatf("stall%0d", i), 32'h20, 32'h1C, 32'h1C, 32'h20, 1'b1);
    end
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    checkIfId("unstall", 32'h24, 32'h20, 32'h20, 32'h24, 1'b1);

    // Redirect overrides stall.
    applyStimulus(1, 0, 1, 0, 32'h80, 32'h0);
    checkOutput("jal_stall.flush", 32'(bus_a.flush_id_ex), 32'h1);
    step();
    checkIfId("jal_stall", 32'h80, 32'h13, 32'h0, 32'h0, 1'b0);

    // JALR beats JAL; bit 0 masked.
    applyStimulus(0, 0, 1, 1, 32'h200, 32'h101);
    checkOutput("jalr.flush", 32'(bus_a.flush_id_ex), 32'h1);
    step();
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkIfId("jalr", 32'h100, 32'h13, 32'h0, 32'h0, 1'b0);
    step();
    checkIfId("jalr.target", 32'h104, 32'h100, 32'h100, 32'h104, 1'b1);

    // Misaligned branch target -> HALT with sticky fault.
    applyStimulus(0, 1, 0, 0, 32'h102, 32'h0);
    checkOutput("mis.flush", 32'(bus_a.flush_id_ex), 32'h1);
    step();
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkIfId("mis", 32'h104, 32'h13, 32'h0, 32'h0, 1'b0);
    checkOutput("mis.fault", 32'(bus_a.fault), 32'h1);
    step();
    step();
    checkIfId("halt", 32'h104, 32'h13, 32'h0, 32'h0, 1'b0);
    checkOutput("halt.fault", 32'(bus_a.fault), 32'h1);
    applyStimulus(0, 0, 1, 0, 32'h300, 32'h0);
    checkOutput("halt.flush", 32'(bus_a.flush_id_ex), 32'h0);
    step();
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    checkIfId("halt.jal", 32'h104, 32'h13, 32'h0, 32'h0, 1'b0);

    // Asynchronous reset mid-HALT.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst.addr", bus_a.imem_addr, 32'h0);
    checkOutput("arst.fault", 32'(bus_a.fault), 32'h0);
    checkOutput("arst.instr", bus_a.if_id_instr, 32'h13);
    step();
    rst = 1'b0;
    step();
    checkIfId("post_rst", 32'h4, 32'h0, 32'h0, 32'h4, 1'b1);
    checkOutput("post_rst.fault", 32'(bus_a.fault), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
